// File: rtl/lsu_ctrl.sv
// Load/store unit controller: request legality check, memory handshake with
// wait states and timeout, store lane replication and load extension.
module lsu_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_we, w_we;
  logic [2:0]       r_funct3, w_funct3;
  logic [1:0]       r_off, w_off;

  logic             r_req_ready, w_req_ready;
  logic             r_resp_valid, w_resp_valid;
  logic [WIDTH-1:0] r_resp_rdata, w_resp_rdata;
  logic             r_resp_fault, w_resp_fault;
  logic             r_mem_req, w_mem_req;
  logic             r_mem_we, w_mem_we;
  logic [WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [3:0]       r_mem_wstrb, w_mem_wstrb;
  logic [WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic             r_busy, w_busy;

  logic             w_illegal;
  logic             w_misaligned;
  logic             w_timeout;
  logic [3:0]       w_strb;
  logic [WIDTH-1:0] w_wdata_rep;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_load_ext;

  // Legality of the incoming request and its store lane layout.
  always_comb begin
    w_illegal    = req_we ? (req_funct3 > 3'd2)
                          : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    w_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_funct3[1:0])
      2'b00: begin
        w_strb      = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_strb      = 4'b0011 << req_addr[1:0];
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        w_strb      = 4'b1111;
        w_wdata_rep = req_wdata;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned read word.
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load_ext = {{(WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{(WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_ext = {{(WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_ext = {{(WIDTH-16){1'b0}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // Next state and next registered output values.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_we         = r_we;
    w_funct3     = r_funct3;
    w_off        = r_off;
    w_mem_addr   = r_mem_addr;
    w_mem_wstrb  = r_mem_wstrb;
    w_mem_wdata  = r_mem_wdata;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_rdata = '0;
    w_resp_fault = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_req_ready && req_valid) begin
          w_we     = req_we;
          w_funct3 = req_funct3;
          w_off    = req_addr[1:0];
          if (w_illegal || w_misaligned) begin
            w_state      = S_RESP;
            w_resp_valid = 1'b1;
            w_resp_fault = 1'b1;
          end else begin
            w_state     = S_ISSUE;
            w_cnt       = '0;
            w_mem_req   = 1'b1;
            w_mem_we    = req_we;
            w_mem_addr  = {req_addr[WIDTH-1:2], 2'b00};
            w_mem_wstrb = req_we ? w_strb : 4'b0000;
            w_mem_wdata = req_we ? w_wdata_rep : '0;
          end
        end
      end
      S_ISSUE: begin
        w_cnt = r_cnt + CW'(1);
        if (mem_gnt) begin
          if (r_we) begin
            w_state      = S_RESP;
            w_resp_valid = 1'b1;
          end else begin
            w_state = S_WAIT;
          end
        end else if (w_timeout) begin
          w_state      = S_RESP;
          w_resp_valid = 1'b1;
          w_resp_fault = 1'b1;
        end else begin
          w_mem_req = 1'b1;
          w_mem_we  = r_we;
        end
      end
      S_WAIT: begin
        w_cnt = r_cnt + CW'(1);
        if (mem_rvalid) begin
          w_state      = S_RESP;
          w_resp_valid = 1'b1;
          w_resp_rdata = w_load_ext;
        end else if (w_timeout) begin
          w_state      = S_RESP;
          w_resp_valid = 1'b1;
          w_resp_fault = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_req_ready = (w_state == S_IDLE);
    w_busy      = (w_state != S_IDLE);
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_we         <= w_we;
      r_funct3     <= w_funct3;
      r_off        <= w_off;
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_fault <= w_resp_fault;
      r_mem_req    <= w_mem_req;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wstrb  <= w_mem_wstrb;
      r_mem_wdata  <= w_mem_wdata;
      r_busy       <= w_busy;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;

endmodule
